// File: rtl/pipemem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Contents: the FSM state encoding, the I/O word offsets inside the
// memory-mapped I/O region, the default I/O region selector, and a
// word-alignment helper.
package pipemem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Word offsets (malu[3:2]) inside the I/O region
    localparam logic [1:0] IO_OFF_LED = 2'd0;
    localparam logic [1:0] IO_OFF_SW  = 2'd1;
    localparam logic [1:0] IO_OFF_KEY = 2'd2;

    // malu[31:28] value that selects the I/O region
    localparam logic [3:0] IO_NIBBLE_DEFAULT = 4'hC;

    // The bus is word addressed: the byte offset bits are forced to zero
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipemem_io.sv
// Memory-mapped I/O block of the MEM stage.
// Holds the LED register and the read mux for LEDs, switches and keys.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   led_we         write strobe for the LED register
//   led_wdata      new LED value
//   sel            word offset inside the I/O region (malu[3:2])
//   sw, key        raw switch and key inputs
//   led            LED register
//   rdata          zero-extended read data for the selected offset
module pipemem_io
    import pipemem_pkg::*;
#(
    parameter int LED_W = 16,
    parameter int SW_W  = 16,
    parameter int KEY_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             led_we,
    input  logic [LED_W-1:0] led_wdata,
    input  logic [1:0]       sel,
    input  logic [SW_W-1:0]  sw,
    input  logic [KEY_W-1:0] key,
    output logic [LED_W-1:0] led,
    output logic [31:0]      rdata
);

    logic [LED_W-1:0] led_r;

    // LED register, written by I/O stores to the LED offset
    always_ff @(posedge clock) begin
        if (reset) begin
            led_r <= {LED_W{1'b0}};
        end else if (led_we) begin
            led_r <= led_wdata;
        end else begin
            led_r <= led_r;
        end
    end

    assign led = led_r;

    // Zero-extending read mux; the unused offset reads as zero
    always_comb begin
        rdata = 32'd0;
        case (sel)
            IO_OFF_LED: rdata[LED_W-1:0] = led_r;
            IO_OFF_SW:  rdata[SW_W-1:0]  = sw;
            IO_OFF_KEY: rdata[KEY_W-1:0] = key;
            default:    rdata            = 32'd0;
        endcase
    end

endmodule

// File: rtl/pipemem_stage.sv
// MEM stage of the 5-stage pipeline.
// Services loads and stores coming out of the EXE/MEM register. RAM
// accesses go over a req/ack bus through an IDLE/REQ/DONE FSM and stall
// the upstream pipeline while outstanding; the I/O region (LEDs,
// switches, keys) completes in a single cycle without stalling.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   mwreg, mm2reg, mwmem         EXE/MEM controls (reg write, load, store)
//   malu, mb, mrn                address/ALU result, store data, dest reg
//   wb_wreg, wb_m2reg            bubble-gated controls to MEM/WB
//   wb_rn, wb_alu, wb_mo         dest reg, ALU result, load data to MEM/WB
//   stall                        freeze PC, IF/ID, ID/EXE, EXE/MEM
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack external memory bus
//   sw, key, led                 I/O region pins
//   bus_err                      sticky bus timeout flag
module pipemem_stage
    import pipemem_pkg::*;
#(
    parameter logic [3:0] IO_NIBBLE = IO_NIBBLE_DEFAULT,
    parameter int         TIMEOUT   = 16,
    parameter int         LED_W     = 16,
    parameter int         SW_W      = 16,
    parameter int         KEY_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             mwmem,
    input  logic [31:0]      malu,
    input  logic [31:0]      mb,
    input  logic [4:0]       mrn,
    output logic             wb_wreg,
    output logic             wb_m2reg,
    output logic [4:0]       wb_rn,
    output logic [31:0]      wb_alu,
    output logic [31:0]      wb_mo,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    input  logic [SW_W-1:0]  sw,
    input  logic [KEY_W-1:0] key,
    output logic [LED_W-1:0] led,
    output logic             bus_err
);

    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      cap_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic             bus_err_r;

    logic             access_s;
    logic             io_s;
    logic             ram_s;
    logic             led_we_s;
    logic [31:0]      io_rdata_s;

    assign access_s = mwmem | mm2reg;
    assign io_s     = (malu[31:28] == IO_NIBBLE);
    assign ram_s    = access_s & ~io_s;
    assign led_we_s = io_s & mwmem & (malu[3:2] == IO_OFF_LED);

    pipemem_io #(
        .LED_W (LED_W),
        .SW_W  (SW_W),
        .KEY_W (KEY_W)
    ) u_io (
        .clock     (clock),
        .reset     (reset),
        .led_we    (led_we_s),
        .led_wdata (mb[LED_W-1:0]),
        .sel       (malu[3:2]),
        .sw        (sw),
        .key       (key),
        .led       (led),
        .rdata     (io_rdata_s)
    );

    // Bus access FSM: launch in IDLE, wait for ack or timeout in REQ,
    // present the captured data for one cycle in DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            cap_r       <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            bus_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (ram_s) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= mwmem;
                        mem_addr_r  <= word_align(malu);
                        mem_wdata_r <= mb;
                        state_r     <= ST_REQ;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // Ack is checked first so a same-cycle expiry loses
                    if (mem_ack) begin
                        cap_r     <= mem_we_r ? 32'd0 : mem_rdata;
                        mem_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        cap_r     <= 32'd0;
                        bus_err_r <= 1'b1;
                        mem_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r   <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r     <= {CNT_W{1'b0}};
                    mem_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign bus_err   = bus_err_r;

    // Low in DONE so the held instruction retires exactly once
    assign stall = ((state_r == ST_IDLE) & ram_s) | (state_r == ST_REQ);

    assign wb_wreg  = mwreg & ~stall;
    assign wb_m2reg = mm2reg & ~stall;
    assign wb_rn    = mrn;
    assign wb_alu   = malu;

    // Load data: captured bus data in DONE, else single-cycle I/O read
    always_comb begin
        wb_mo = 32'd0;
        if (state_r == ST_DONE) begin
            wb_mo = cap_r;
        end else if (io_s & mm2reg) begin
            wb_mo = io_rdata_s;
        end else begin
            wb_mo = 32'd0;
        end
    end

endmodule

// File: doc/pipemem_stage.md
Name: pipemem_stage

Overview:
MEM stage of the 5-stage pipeline. Consumes the EXE/MEM register outputs and services loads and stores. RAM accesses go over an external req/ack memory bus; a small memory-mapped I/O region covers LEDs, switches and keys. Produces load data and controls for the MEM/WB register, and asserts a stall that freezes PC, IF/ID, ID/EXE and EXE/MEM while a bus access is outstanding.

Parameters:
IO_NIBBLE, 4'hC, malu[31:28] value selecting the I/O region
TIMEOUT, 16, maximum cycles in REQ before the access is aborted (≥2)
LED_W, 16, LED register width
SW_W, 16, switch input width
KEY_W, 4, key input width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
mwreg  in  1  register-write control from EXE/MEM
mm2reg  in  1  load (memory-to-register) control
mwmem  in  1  store control
malu  in  32  effective address / ALU result
mb  in  32  store data
mrn  in  5  destination register number
wb_wreg  out  1  register write to MEM/WB (bubble-gated)
wb_m2reg  out  1  mm2reg to MEM/WB (bubble-gated)
wb_rn  out  5  mrn pass-through
wb_alu  out  32  malu pass-through
wb_mo  out  32  load data
stall  out  1  freeze upstream pipeline registers
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  32  word address
mem_wdata  out  32  bus write data
mem_rdata  in  32  bus read data
mem_ack  in  1  bus acknowledge; single-cycle pulse
sw  in  SW_W  switch inputs
key  in  KEY_W  key inputs
led  out  LED_W  LED register
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (sync, high) forces: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, led=0, bus_err=0, timeout counter=0, captured data=0. Reset mid-access abandons the transaction; mem_req is low in the cycle after the reset edge.
- Definitions: access = mwmem | mm2reg; io = (malu[31:28]==IO_NIBBLE); ram = access & ~io.
- Addressing is word-only. mem_addr = {malu[31:2],2'b00}. malu[1:0] is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If ram: at the clock edge, register addr, mem_we=mwmem and mem_wdata=mb; set mem_req=1; go to REQ.
  - Otherwise stay in IDLE.
  - mem_ack is ignored in IDLE.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Counter increments each cycle.
  - On mem_ack: capture mem_rdata (capture 0 for stores), drop mem_req, go to DONE.
  - Otherwise, when counter==TIMEOUT-1: capture 0, set bus_err=1, drop mem_req, go to DONE.
  - If ack and expiry occur in the same cycle, ack wins and bus_err is not set.
- DONE: one cycle, then IDLE. The counter clears on entry to IDLE.
- stall (combinational) = (state==IDLE & ram) | (state==REQ). It is low in DONE, so the held instruction retires at the end of DONE and is not re-issued.
- Bubble: wb_wreg = mwreg & ~stall; wb_m2reg = mm2reg & ~stall.
- Load latency: RAM load minimum 3 cycles (IDLE→REQ, ack in first REQ cycle, DONE). I/O access: 1 cycle, no stall.
- wb_mo selection:
  - DONE: captured data.
  - io & mm2reg: malu[3:2]==0 → zero-extended led; 1 → zero-extended sw; 2 → zero-extended key; 3 → 0.
  - Otherwise: 0.
- I/O store (io & mwmem & malu[3:2]==0): led <= mb[LED_W-1:0] at the clock edge. Other I/O store offsets are ignored.
- bus_err clears only on reset.

Decomposition:
- Shared pipeline package holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2)
  - I/O offsets (LED=2'd0, SW=2'd1, KEY=2'd2)
  - IO_NIBBLE default
- One natural sub-module, pipemem_io: LED register plus read mux for switches and keys.
- The FSM and bus interface stay in the top module.

Test Plan:
- Load, ack after 2 REQ cycles: mm2reg=1, malu=0x00000104, mem_rdata=0xDEADBEEF → mem_addr=0x104, stall high for 3 cycles, DONE wb_mo=0xDEADBEEF with wb_wreg=1, bus_err=0.
- Store: mwmem=1, malu=0x00000203, mb=0x12345678, ack in first REQ cycle → mem_addr=0x200, mem_we=1, mem_wdata=0x12345678, stall for 2 cycles, wb_wreg=0.
- Timeout: load with no ack, TIMEOUT=16 → mem_req drops after 16 REQ cycles, wb_mo=0, bus_err=1 and stays 1 until reset.
- I/O: store mb=0x0000A5A5 to 0xC0000000 → led=0xA5A5 next cycle, no stall. Load 0xC0000004 with sw=0x3C3C → wb_mo=0x00003C3C in the same cycle.
- Ack and expiry in the same cycle → data captured, bus_err stays 0. A stray mem_ack in IDLE → no state change.
- Reset asserted in the 3rd REQ cycle → next cycle state=IDLE, mem_req=0, stall=0, led=0.
